// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the accumulator-core fetch/execute sequencer.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM_WAIT, HALTED} seq_state_t;

  localparam int kBR_OFF_W = 7;

  // Loads are encoded as MemtoReg == 1; any store or load needs the memory phase.
  function automatic logic is_mem_op(input logic mem_write, input logic [1:0] memtoreg);
    return mem_write || (memtoreg == 2'd1);
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// Program counter register with next-PC selection: clear, increment or relative branch.
module pc_unit
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 load_zero,
  input  logic                 advance,
  input  logic                 take_branch,
  input  logic [kBR_OFF_W-1:0] offset,
  output logic [PC_W-1:0]      pc
);

  logic signed [PC_W-1:0] off_sx;
  logic [PC_W-1:0]        pc_next;

  assign off_sx = {{(PC_W-kBR_OFF_W){offset[kBR_OFF_W-1]}}, offset};

  // Modulo-2^PC_W arithmetic: wrap in either direction is intentional.
  always_comb begin
    pc_next = pc;
    if (load_zero) begin
      pc_next = '0;
    end else if (advance) begin
      if (take_branch) pc_next = pc + off_sx;
      else             pc_next = pc + PC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) pc <= '0;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns IR, PC, commit strobe, data-memory
// handshake and the retired-instruction counter.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_data,
  output logic [8:0]       ir,
  input  logic             branch_in,
  input  logic             halt_in,
  input  logic             mem_write_in,
  input  logic [1:0]       memtoreg_in,
  input  logic             cond_flag,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             commit,
  output logic             done,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired
);

  seq_state_t state, state_nxt;
  logic load_zero, advance, take_branch, ir_load, req_set, req_clr, clr_ret;

  pc_unit #(.PC_W(PC_W)) u_pc (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .load_zero   (load_zero),
    .advance     (advance),
    .take_branch (take_branch),
    .offset      (ir[kBR_OFF_W-1:0]),
    .pc          (pc)
  );

  assign imem_addr = pc;
  assign done      = (state == HALTED);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    load_zero   = 1'b0;
    advance     = 1'b0;
    take_branch = 1'b0;
    ir_load     = 1'b0;
    req_set     = 1'b0;
    req_clr     = 1'b0;
    clr_ret     = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = FETCH;
          load_zero = 1'b1;
          clr_ret   = 1'b1;
        end
      end
      FETCH: begin
        ir_load   = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (halt_in) begin
          state_nxt = HALTED;
        end else if (is_mem_op(mem_write_in, memtoreg_in)) begin
          req_set   = 1'b1;
          state_nxt = MEM_WAIT;
        end else begin
          commit      = 1'b1;
          advance     = 1'b1;
          take_branch = branch_in && cond_flag;
          state_nxt   = FETCH;
        end
      end
      MEM_WAIT: begin
        // Memory instructions never branch, so completion is a plain increment.
        if (mem_ack) begin
          commit    = 1'b1;
          advance   = 1'b1;
          req_clr   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ir      <= '0;
      mem_req <= 1'b0;
      retired <= '0;
    end else begin
      if (ir_load) ir <= imem_data;
      if (req_set)      mem_req <= 1'b1;
      else if (req_clr) mem_req <= 1'b0;
      // Counter saturates rather than wrapping.
      if (clr_ret)                  retired <= '0;
      else if (commit && !(&retired)) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle vector table plus hand-written corner sequences.
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        start;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic [8:0]  ir;
  logic        branch_in, halt_in, mem_write_in;
  logic [1:0]  memtoreg_in;
  logic        cond_flag;
  logic        mem_req, mem_ack, commit, done;
  logic [9:0]  pc;
  logic [15:0] retired;

  logic [8:0] imem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign imem_data = imem[imem_addr];

  // Stub decoder for the few opcodes the bench uses.
  always_comb begin
    branch_in    = 1'b0;
    halt_in      = 1'b0;
    mem_write_in = 1'b0;
    memtoreg_in  = 2'd0;
    case (ir)
      9'h1FF: halt_in = 1'b1;
      9'h100: memtoreg_in = 2'd1;
      9'h180: mem_write_in = 1'b1;
      9'h0C0, 9'h000: ;
      default: branch_in = (ir[8:7] == 2'b01);
    endcase
  end

  instr_sequencer #(.PC_W(10), .CNT_W(16)) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .ir           (ir),
    .branch_in    (branch_in),
    .halt_in      (halt_in),
    .mem_write_in (mem_write_in),
    .memtoreg_in  (memtoreg_in),
    .cond_flag    (cond_flag),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .commit       (commit),
    .done         (done),
    .pc           (pc),
    .retired      (retired)
  );

  typedef struct {
    logic        start, cond, ack;
    logic        commit, req, done;
    logic [9:0]  pc;
    logic [15:0] ret;
    logic [8:0]  ir;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t mk(input logic s, input logic c, input logic a,
                              input logic cm, input logic rq, input logic dn,
                              input logic [9:0] p, input logic [15:0] r, input logic [8:0] i);
    vec_t v;
    v.start = s; v.cond = c; v.ack = a;
    v.commit = cm; v.req = rq; v.done = dn;
    v.pc = p; v.ret = r; v.ir = i;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 1024; k++) imem[k] = 9'h000;
  endtask

  task automatic do_reset();
    RST_n = 1'b0; start = 1'b0; mem_ack = 1'b0; cond_flag = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;
  endtask

  initial begin
    // Main program: inc, load, store, inc, inc, branch -2, halt.
    clear_imem();
    imem[0] = 9'h0C0; imem[1] = 9'h100; imem[2] = 9'h180; imem[3] = 9'h0C0;
    imem[4] = 9'h0C0; imem[5] = 9'h0FE; imem[6] = 9'h1FF;

    //              st cd ak  cm rq dn  pc ret ir
    vecs[0]  = mk(1, 0, 0,  0, 0, 0,  0, 0, 9'h000);
    vecs[1]  = mk(0, 0, 0,  0, 0, 0,  0, 0, 9'h000);
    vecs[2]  = mk(0, 0, 0,  1, 0, 0,  0, 0, 9'h0C0);
    vecs[3]  = mk(0, 0, 0,  0, 0, 0,  1, 1, 9'h0C0);
    vecs[4]  = mk(0, 0, 0,  0, 0, 0,  1, 1, 9'h100);
    vecs[5]  = mk(0, 0, 0,  0, 1, 0,  1, 1, 9'h100);
    vecs[6]  = mk(0, 0, 0,  0, 1, 0,  1, 1, 9'h100);
    vecs[7]  = mk(0, 0, 1,  1, 1, 0,  1, 1, 9'h100);
    vecs[8]  = mk(0, 0, 0,  0, 0, 0,  2, 2, 9'h100);
    vecs[9]  = mk(0, 0, 0,  0, 0, 0,  2, 2, 9'h180);
    vecs[10] = mk(0, 0, 1,  1, 1, 0,  2, 2, 9'h180);
    vecs[11] = mk(0, 0, 1,  0, 0, 0,  3, 3, 9'h180);
    vecs[12] = mk(0, 0, 0,  1, 0, 0,  3, 3, 9'h0C0);
    vecs[13] = mk(0, 0, 0,  0, 0, 0,  4, 4, 9'h0C0);
    vecs[14] = mk(0, 0, 0,  1, 0, 0,  4, 4, 9'h0C0);
    vecs[15] = mk(0, 0, 0,  0, 0, 0,  5, 5, 9'h0C0);
    vecs[16] = mk(1, 1, 0,  1, 0, 0,  5, 5, 9'h0FE);
    vecs[17] = mk(0, 0, 0,  0, 0, 0,  3, 6, 9'h0FE);
    vecs[18] = mk(0, 0, 0,  1, 0, 0,  3, 6, 9'h0C0);
    vecs[19] = mk(0, 0, 0,  0, 0, 0,  4, 7, 9'h0C0);
    vecs[20] = mk(0, 0, 0,  1, 0, 0,  4, 7, 9'h0C0);
    vecs[21] = mk(0, 0, 0,  0, 0, 0,  5, 8, 9'h0C0);
    vecs[22] = mk(0, 0, 0,  1, 0, 0,  5, 8, 9'h0FE);
    vecs[23] = mk(0, 0, 0,  0, 0, 0,  6, 9, 9'h0FE);
    vecs[24] = mk(0, 0, 0,  0, 0, 0,  6, 9, 9'h1FF);
    vecs[25] = mk(0, 0, 0,  0, 0, 1,  6, 9, 9'h1FF);
    vecs[26] = mk(1, 0, 0,  0, 0, 1,  6, 9, 9'h1FF);
    vecs[27] = mk(0, 0, 0,  0, 0, 0,  0, 0, 9'h1FF);
    vecs[28] = mk(0, 0, 0,  1, 0, 0,  0, 0, 9'h0C0);

    RST_n = 1'b0; start = 1'b0; mem_ack = 1'b0; cond_flag = 1'b0;
    @(negedge CLK);
    chk("rst pc", pc, 0);
    chk("rst ir", ir, 0);
    chk("rst retired", retired, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst commit", commit, 0);
    chk("rst done", done, 0);
    @(posedge CLK);
    #1 RST_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      start     = vecs[i].start;
      cond_flag = vecs[i].cond;
      mem_ack   = vecs[i].ack;
      @(negedge CLK);
      chk($sformatf("v%0d commit", i), commit, vecs[i].commit);
      chk($sformatf("v%0d mem_req", i), mem_req, vecs[i].req);
      chk($sformatf("v%0d done", i), done, vecs[i].done);
      chk($sformatf("v%0d pc", i), pc, vecs[i].pc);
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].pc);
      chk($sformatf("v%0d retired", i), retired, vecs[i].ret);
      chk($sformatf("v%0d ir", i), ir, vecs[i].ir);
      @(posedge CLK);
      #1;
    end
    start = 1'b0; mem_ack = 1'b0; cond_flag = 1'b0;

    // PC wrap both ways: branch -1 from 0, then increment from 1023.
    clear_imem();
    imem[0] = 9'h0FF; imem[1023] = 9'h0C0;
    do_reset();
    start = 1'b1; tick();
    start = 1'b0; tick();
    cond_flag = 1'b1;
    chk("wrap br commit", commit, 1);
    tick();
    cond_flag = 1'b0;
    chk("wrap back pc", pc, 10'd1023);
    tick();
    chk("wrap inc commit", commit, 1);
    tick();
    chk("wrap fwd pc", pc, 0);
    chk("wrap retired", retired, 2);

    // Halt after two increments.
    clear_imem();
    imem[0] = 9'h0C0; imem[1] = 9'h0C0; imem[2] = 9'h1FF;
    do_reset();
    start = 1'b1; tick();
    start = 1'b0;
    repeat (4) tick();
    tick();
    chk("halt exec commit", commit, 0);
    tick();
    chk("halt done", done, 1);
    chk("halt retired", retired, 2);
    chk("halt pc", pc, 2);
    tick();
    chk("halt frozen pc", pc, 2);

    // Reset asserted while a load waits for its acknowledge.
    clear_imem();
    imem[0] = 9'h0C0; imem[1] = 9'h100;
    do_reset();
    start = 1'b1; tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort pre mem_req", mem_req, 1);
    chk("abort pre retired", retired, 1);
    #2;
    RST_n = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("abort mem_req", mem_req, 0);
    chk("abort commit", commit, 0);
    chk("abort pc", pc, 0);
    chk("abort retired", retired, 0);
    tick();
    RST_n = 1'b1;
    tick();
    chk("late ack commit", commit, 0);
    chk("late ack mem_req", mem_req, 0);
    tick();
    chk("late ack ir", ir, 0);
    chk("late ack retired", retired, 0);
    mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
